// File: rtl/op_sequencer.sv
// -----------------------------------------------------------------------------
// op_sequencer
//   Sequences one decoded instruction at a time through an ALU and a TX stage:
//   IDLE -> EXEC -> HANDOFF -> DRAIN -> IDLE.
//
// Ports
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   instr_valid/_opcode  : decoded instruction from the RX stage
//   instr_ready          : high only in IDLE (instruction is taken this cycle)
//   alu_start/alu_opcode : one-cycle launch pulse and latched opcode for the ALU
//   alu_done             : ALU finished (pulse or level), honoured only in EXEC
//   res_valid/res_ready  : result handshake towards the TX stage (HANDOFF only)
//   tx_done              : TX frame finished, honoured only in DRAIN
//   busy                 : high in every state except IDLE
//   op_count             : completed operations, wraps 255 -> 0
//   timeout_err, err_clr : sticky drain-timeout flag and its clear
//
// Configuration
//   OP_SEQUENCER_TIMEOUT_EN : when defined, a watchdog bounds the time spent in
//   DRAIN to TIMEOUT_CYCLES cycles; on expiry timeout_err is set and the FSM
//   returns to IDLE without counting the operation. When undefined, DRAIN waits
//   for tx_done indefinitely and timeout_err is tied low.
// -----------------------------------------------------------------------------
module op_sequencer #(
  parameter int OPC_W          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [OPC_W-1:0] instr_opcode,
  output logic             instr_ready,
  output logic             alu_start,
  output logic [OPC_W-1:0] alu_opcode,
  input  logic             alu_done,
  output logic             res_valid,
  input  logic             res_ready,
  input  logic             tx_done,
  output logic             busy,
  output logic [7:0]       op_count,
  output logic             timeout_err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_HANDOFF = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             alu_start_q, alu_start_d;
  logic [OPC_W-1:0] alu_opcode_q, alu_opcode_d;
  logic [7:0]       op_count_q, op_count_d;

`ifdef OP_SEQUENCER_TIMEOUT_EN
  // Last counter value before expiry: DRAIN lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        wd_expire_s;
`endif

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_d      = state_q;
    alu_start_d  = 1'b0;
    alu_opcode_d = alu_opcode_q;
    op_count_d   = op_count_q;
`ifdef OP_SEQUENCER_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
    wd_expire_s  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          alu_opcode_d = instr_opcode;
          alu_start_d  = 1'b1;
          state_d      = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (alu_done) begin
          state_d = ST_HANDOFF;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_HANDOFF: begin
        // tx_done is deliberately not looked at here, even alongside res_ready.
        if (res_ready) begin
          state_d = ST_DRAIN;
`ifdef OP_SEQUENCER_TIMEOUT_EN
          wd_cnt_d = 16'd0;
`endif
        end else begin
          state_d = ST_HANDOFF;
        end
      end
      ST_DRAIN: begin
`ifdef OP_SEQUENCER_TIMEOUT_EN
        if (tx_done) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = ST_IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          wd_expire_s = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
          state_d  = ST_DRAIN;
        end
`else
        if (tx_done) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_start_q  <= 1'b0;
      alu_opcode_q <= '0;
      op_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      alu_start_q  <= alu_start_d;
      alu_opcode_q <= alu_opcode_d;
      op_count_q   <= op_count_d;
    end
  end

`ifdef OP_SEQUENCER_TIMEOUT_EN
  // Sticky timeout flag: a same-cycle expiry beats err_clr.
  always_comb begin
    timeout_err_d = timeout_err_q;
    if (wd_expire_s) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // Watchdog counter and timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q      <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // Without the watchdog, err_clr and TIMEOUT_CYCLES have no effect.
  logic unused_cfg_s;
  assign unused_cfg_s = err_clr ^ (TIMEOUT_CYCLES == 32'sd0);
  assign timeout_err  = 1'b0;
`endif

  assign instr_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_HANDOFF);
  assign busy        = (state_q != ST_IDLE);
  assign alu_start   = alu_start_q;
  assign alu_opcode  = alu_opcode_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_op_sequencer
//   Directed stimulus for op_sequencer. The driver pushes expected opcodes,
//   res_valid window lengths and end-of-operation op_count values into queues;
//   a monitor on the falling clock edge pops and compares them whenever the
//   DUT shows an alu_start pulse, closes a res_valid window or leaves busy.
// -----------------------------------------------------------------------------
module tb_op_sequencer;

  localparam int OPC_W = 4;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             instr_valid = 1'b0;
  logic [OPC_W-1:0] instr_opcode = '0;
  logic             instr_ready;
  logic             alu_start;
  logic [OPC_W-1:0] alu_opcode;
  logic             alu_done = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             tx_done = 1'b0;
  logic             busy;
  logic [7:0]       op_count;
  logic             timeout_err;
  logic             err_clr = 1'b0;

  op_sequencer #(.OPC_W(OPC_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_opcode (instr_opcode),
    .instr_ready  (instr_ready),
    .alu_start    (alu_start),
    .alu_opcode   (alu_opcode),
    .alu_done     (alu_done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .tx_done      (tx_done),
    .busy         (busy),
    .op_count     (op_count),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [OPC_W-1:0] exp_opc_q[$];
  int               exp_rv_q[$];
  logic [7:0]       exp_cnt_q[$];
  logic [7:0]       model_cnt = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor state
  int   st_w = 0;
  int   rv_w = 0;
  logic rv_ir_bad = 1'b0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (alu_start === 1'b1) begin
      if (st_w == 0) begin
        if (exp_opc_q.size() == 0) chk("alu_start_unexpected", 32'd1, 32'd0);
        else chk("alu_opcode", 32'(alu_opcode), 32'(exp_opc_q.pop_front()));
      end
      st_w++;
    end else if (st_w != 0) begin
      chk("alu_start_width", st_w, 32'd1);
      st_w = 0;
    end

    if (res_valid === 1'b1) begin
      rv_w++;
      if (instr_ready !== 1'b0) rv_ir_bad = 1'b1;
    end else if (rv_w != 0) begin
      if (exp_rv_q.size() == 0) chk("res_valid_unexpected", 32'd1, 32'd0);
      else chk("res_valid_len", rv_w, exp_rv_q.pop_front());
      chk("instr_ready_in_handoff", 32'(rv_ir_bad), 32'd0);
      rv_w      = 0;
      rv_ir_bad = 1'b0;
    end

    if (busy_prev === 1'b1 && busy === 1'b0) begin
      if (exp_cnt_q.size() == 0) chk("busy_fall_unexpected", 32'd1, 32'd0);
      else chk("op_count", 32'(op_count), 32'(exp_cnt_q.pop_front()));
    end
    busy_prev = busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for instr_ready, then present one instruction for one edge.
  task automatic accept(input logic [OPC_W-1:0] opc);
    int k;
    k = 0;
    while (instr_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    if (instr_ready !== 1'b1) chk("wait_instr_ready", 32'(instr_ready), 32'd1);
    instr_valid  = 1'b1;
    instr_opcode = opc;
    exp_opc_q.push_back(opc);
    step();
    instr_valid = 1'b0;
  endtask

  // Drive the remainder of an accepted operation.
  // mode 0: tx_done after txw cycles; mode 1: no tx_done (timeout expected);
  // mode 2: long wait in DRAIN with err_clr, then tx_done.
  task automatic finish(input logic [OPC_W-1:0] opc, input int aw, input int rw,
                        input int txw, input bit spur_tx, input int mode);
    int n;
    repeat (aw) step();
    exp_rv_q.push_back(rw + 1);
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    if (spur_tx) tx_done = 1'b1;
    repeat (rw) step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    tx_done   = 1'b0;
    if (spur_tx) begin
      chk("drain_after_spur_tx_busy", 32'(busy), 32'd1);
      chk("drain_after_spur_tx_rv", 32'(res_valid), 32'd0);
    end
    if (mode == 1) begin
      exp_cnt_q.push_back(model_cnt);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        step();
        n++;
      end
      chk("drain_timeout_cycles", n, TMO);
      chk("timeout_err_set", 32'(timeout_err), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("timeout_err_clr", 32'(timeout_err), 32'd0);
    end else begin
      if (mode == 2) begin
        repeat (20) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("drain_no_timeout_busy", 32'(busy), 32'd1);
        chk("drain_no_timeout_err", 32'(timeout_err), 32'd0);
      end else begin
        repeat (txw) step();
      end
      model_cnt = model_cnt + 8'd1;
      exp_cnt_q.push_back(model_cnt);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk("idle_after_tx", 32'(busy), 32'd0);
    end
    chk("alu_opcode_hold", 32'(alu_opcode), 32'(opc));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();

    // Basic operation: opcode 3, alu_done 2 cycles later, res_ready at once.
    accept(4'h3);
    finish(4'h3, 1, 0, 10, 1'b0, 0);

    // Backpressure: res_ready low for 5 HANDOFF cycles.
    accept(4'h5);
    finish(4'h5, 0, 5, 2, 1'b0, 0);

    // Spurious alu_done in IDLE is ignored.
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("spur_alu_done_busy", 32'(busy), 32'd0);
    chk("spur_alu_done_cnt", 32'(op_count), 32'(model_cnt));

    // tx_done held through HANDOFF (including the res_ready cycle) is ignored.
    accept(4'h9);
    finish(4'h9, 0, 2, 1, 1'b1, 0);

    // DRAIN watchdog behaviour.
    accept(4'hC);
`ifdef OP_SEQUENCER_TIMEOUT_EN
    finish(4'hC, 0, 0, 0, 1'b0, 1);
`else
    finish(4'hC, 0, 0, 0, 1'b0, 2);
`endif

    // Asynchronous reset during EXEC with instr_valid held high.
    accept(4'h6);
    instr_valid  = 1'b1;
    instr_opcode = 4'hA;
    step();
    step();
    exp_cnt_q.push_back(8'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu_start", 32'(alu_start), 32'd0);
    chk("mid_rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("mid_rst_op_count", 32'(op_count), 32'd0);
    chk("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    model_cnt = 8'd0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    exp_opc_q.push_back(4'hA);
    step();
    instr_valid = 1'b0;
    chk("post_rst_accept_busy", 32'(busy), 32'd1);
    chk("post_rst_accept_start", 32'(alu_start), 32'd1);
    finish(4'hA, 0, 0, 0, 1'b0, 0);

    // 255 more minimum-latency operations: 256 in total since reset.
    for (int i = 1; i < 256; i++) begin
      logic [OPC_W-1:0] o;
      o = OPC_W'(i);
      accept(o);
      finish(o, 0, 0, 0, 1'b0, 0);
    end
    chk("wrap_op_count", 32'(op_count), 32'd0);
    chk("wrap_instr_ready", 32'(instr_ready), 32'd1);

    repeat (3) step();
    chk("queue_opc_empty", exp_opc_q.size(), 32'd0);
    chk("queue_rv_empty", exp_rv_q.size(), 32'd0);
    chk("queue_cnt_empty", exp_cnt_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL have parameter OPC_W, default 4, opcode width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, drain watchdog limit in clk cycles (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1, the single system clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port instr_valid, input, 1, RX stage holds a decoded instruction.
REQ-006 SHALL have port instr_opcode, input, OPC_W, opcode of that instruction.
REQ-007 SHALL have port instr_ready, output, 1, sequencer accepts the instruction.
REQ-008 SHALL have port alu_start, output, 1, one-cycle ALU launch pulse.
REQ-009 SHALL have port alu_opcode, output, OPC_W, latched opcode presented to the ALU.
REQ-010 SHALL have port alu_done, input, 1, ALU result available (pulse or level).
REQ-011 SHALL have port res_valid, output, 1, result offered to the TX stage.
REQ-012 SHALL have port res_ready, input, 1, TX stage accepts the result.
REQ-013 SHALL have port tx_done, input, 1, TX stage finished the 5-byte frame.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port op_count, output, 8, number of completed operations.
REQ-016 SHALL have port timeout_err, output, 1, sticky drain-timeout flag.
REQ-017 SHALL have port err_clr, input, 1, clears timeout_err.

Function
REQ-018 SHALL implement a FSM with states IDLE, EXEC, HANDOFF and DRAIN.
REQ-019 SHALL drive instr_ready=1 only in IDLE, combinationally from state.
REQ-020 SHALL, in IDLE when instr_valid=1, latch instr_opcode into alu_opcode, register alu_start=1 for exactly the next cycle, and enter EXEC.
REQ-021 SHALL, in EXEC, stay until alu_done=1, then enter HANDOFF; alu_done in any other state is ignored.
REQ-022 SHALL, in HANDOFF, drive res_valid=1 and hold it until res_ready=1 is sampled, then enter DRAIN; res_valid is 0 in every other state.
REQ-023 SHALL, in DRAIN, enter IDLE on tx_done=1 and increment op_count by 1 in the same edge; op_count wraps 255->0.
REQ-024 SHALL ignore tx_done outside DRAIN, including tx_done coincident with res_ready in HANDOFF.
REQ-025 SHALL hold alu_opcode stable from the IDLE->EXEC edge until the next accepted instruction.
REQ-026 SHALL give err_clr priority below a same-cycle timeout set (set wins).
REQ-027 SHALL have a minimum latency of 4 cycles from instr_valid acceptance to re-entering IDLE (alu_done, res_ready and tx_done each at their earliest).

Reset
REQ-028 SHALL, on rst_n=0 asserted at any time (including mid-operation), asynchronously force state=IDLE, alu_start=0, alu_opcode=0, op_count=0, timeout_err=0 and watchdog counter=0, so that after reset instr_ready=1 and res_valid=0 and busy=0.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro OP_SEQUENCER_TIMEOUT_EN defined, count cycles spent in DRAIN (counter cleared on DRAIN entry), and when the count reaches TIMEOUT_CYCLES without tx_done, set timeout_err=1, enter IDLE and leave op_count unchanged.
REQ-031 SHALL, with OP_SEQUENCER_TIMEOUT_EN undefined, omit the counter, wait in DRAIN indefinitely, tie timeout_err to 0 and ignore err_clr.

Verification
REQ-032 SHALL cover: instr_valid with opcode 4'h3, alu_done 2 cycles later, res_ready at once, tx_done 10 cycles later -> alu_start pulse of 1 cycle, alu_opcode=3, one res_valid cycle, op_count 0->1.
REQ-033 SHALL cover: res_ready held low 5 cycles in HANDOFF -> res_valid stays 1 for 6 cycles and instr_ready stays 0.
REQ-034 SHALL cover: 256 back-to-back operations -> op_count returns to 0 and instr_ready=1.
REQ-035 SHALL cover, with the macro defined and TIMEOUT_CYCLES=8: no tx_done -> timeout_err=1 and IDLE after 8 DRAIN cycles; err_clr then clears it.
REQ-036 SHALL cover: rst_n pulled low during EXEC with instr_valid held high -> immediate IDLE with all outputs at reset values, and a new acceptance on the first edge after release.
REQ-037 SHALL cover: spurious alu_done in IDLE and tx_done in HANDOFF -> no state change and op_count unchanged.
